ysyx_23060240_axi_rd_arbiter: RTL and testbench
===============================================

# ysyx_23060240_axi_rd_arbiter

Two-master, one-slave AXI4-Lite read-channel arbiter that shares the single SRAM read port between the instruction fetch unit (master 0, IFU) and the load/store unit (master 1, LSU). It serialises requests, one outstanding transaction at a time. It registers the slave's read data in a one-entry response buffer, so a master that is not ready when the slave pulses `rvalid` still receives its data. It sits between the IFU/LSU read ports and the SRAM slave's `araddr/arvalid/arready/rdata/rvalid/rready` channel.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, read data width
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low (asserted when 0)
- m0_araddr  in  ADDR_W  IFU read address
- m0_arvalid  in  1  IFU address valid
- m0_arready  out  1  IFU address accepted
- m0_rdata  out  DATA_W  IFU read data
- m0_rvalid  out  1  IFU data valid
- m0_rready  in  1  IFU data ready
- m1_araddr, m1_arvalid, m1_arready, m1_rdata, m1_rvalid, m1_rready: same directions and widths as the m0_* ports, for the LSU
- s_araddr  out  ADDR_W  slave address
- s_arvalid  out  1  slave address valid
- s_arready  in  1  slave address ready
- s_rdata  in  DATA_W  slave read data
- s_rvalid  in  1  slave data valid (single-cycle pulse permitted)
- s_rready  out  1  slave data ready
- busy  out  1  high in any state other than IDLE
- owner  out  1  current or last granted master (0 = IFU, 1 = LSU)

## Operation
- FSM states: IDLE, ADDR, WAIT, RESP. A registered `owner` bit selects the master.
- **IDLE**
  - All `*_arready`, `*_rvalid` and `s_arvalid` are 0.
  - If either `mX_arvalid` is high, the winner is latched into `owner` and the FSM moves to ADDR.
  - Winner selection is set by the Configuration section.
- **ADDR**
  - `s_araddr = m[owner]_araddr` and `s_arvalid = m[owner]_arvalid`.
  - `m[owner]_arready = s_arready`. The non-owner's `arready` is 0.
  - On `s_arvalid && s_arready`, the FSM moves to WAIT.
  - If the owner drops `arvalid` (an AXI violation), the FSM stays in ADDR.
- **WAIT**
  - `s_rready = 1`.
  - On `s_rvalid`, `s_rdata` is captured into `rbuf` and the FSM moves to RESP.
- **RESP**
  - `m[owner]_rvalid = 1` and `m[owner]_rdata = rbuf`. `s_rready = 0`.
  - On `m[owner]_rready`, the FSM moves to IDLE.
- **Non-owner outputs:** the non-owner's `rvalid` is always 0, and its `rdata` is 0.
- **Request ordering:** a request arriving during a transaction waits. It is evaluated in IDLE, never preempting the current transaction.
- **Unchanged register:** `owner` keeps its value after a transaction completes.
- `s_araddr` outside ADDR is 0.

## Timing
- **Reset (rst = 0), asynchronous:**
  - FSM goes to IDLE, `rbuf` = 0, `owner` = 0, `last` = 1.
  - All outputs are 0, including `s_rready` and `busy`.
  - Reset mid-transaction abandons the transaction; the slave is not notified.
- **Arbitration:** 1 cycle. A request seen in IDLE at edge N reaches `s_arvalid` from edge N+1.
- **Minimum transaction length:** 4 cycles (IDLE, ADDR, WAIT, RESP), assuming `s_arready` in the first ADDR cycle, `s_rvalid` in the first WAIT cycle, and `rready` held high.
- **Response latency:** `m[owner]_rvalid` rises the cycle after `s_rvalid` is sampled.
- **Back-to-back:** the RESP→IDLE cycle is mandatory, so the next grant occurs at the earliest 1 cycle after the RESP handshake.
- **Stability:** `rdata` and `rvalid` are stable throughout RESP until the handshake.
- **Combinational paths:** only the address-phase pass-through (`araddr`/`arvalid`/`arready`) is combinational in ADDR. The data path is registered.

## Configuration
- `ARB_RR_EN` defined: round-robin arbitration.
  - The `last` register records the master granted by the most recent IDLE decision.
  - On simultaneous requests, the grant goes to `!last`.
  - After reset `last` = 1, so IFU wins the first tie.
- `ARB_RR_EN` undefined: fixed priority.
  - LSU (m1) wins all ties.
  - IFU is granted only when `m1_arvalid` = 0 in IDLE.
  - The `last` register is absent.
- A single requester is granted immediately in either mode.

## Test plan
- **IFU only:** `m0_araddr = 0x80000000`, `s_arready = 1`, slave returns `0x00000413` one cycle after the AR handshake, `m0_rready = 1`.
  - Expect `m0_rvalid` with `0x00000413`, 4 cycles after request; `owner = 0`; `m1_*` outputs all 0.
- **Simultaneous requests, m0 = 0x80000004 and m1 = 0x80001000, both held:**
  - With `ARB_RR_EN`: order m0, m1.
  - Without: order m1, m0.
- **Slave rvalid as a 1-cycle pulse, `m1_rready` low for 3 cycles after it:**
  - Expect `m1_rvalid` held for 3 cycles with `rbuf` value `0xDEADBEEF` stable.
  - Expect `s_rready` = 0 during those cycles; handshake completes on the cycle `m1_rready` = 1.
- **`s_arready` delayed 2 cycles in ADDR:**
  - Expect `s_arvalid` and `s_araddr` stable; `m0_arready` mirrors `s_arready`; no state change until the handshake.
- **m1 requests while an m0 transaction is in WAIT:**
  - Expect `m1_arready` = 0 until after the m0 RESP handshake.
  - m1 is granted in the following IDLE cycle.
- **Reset mid-transaction:** assert `rst = 0` asynchronously while in WAIT, then release.
  - Expect immediate IDLE and all outputs 0.
  - The next single request completes normally in 4 cycles.

Source files
------------

// File: rtl/ysyx_23060240_axi_rd_arbiter.sv
// rtl/ysyx_23060240_axi_rd_arbiter.sv - two-master AXI4-Lite read-channel arbiter
//
// Shares one SRAM read port between the IFU (master 0) and the LSU (master 1).
// One transaction is outstanding at a time. Slave read data is held in a
// one-entry buffer so a master that stalls rready still receives it.
//
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   m0_* / m1_*        IFU / LSU read address and read data channels
//   s_*                slave read address and read data channel
//   busy               high whenever the arbiter is not idle
//   owner              current or last granted master (0 = IFU, 1 = LSU)
//
// Build option: ARB_RR_EN selects round-robin arbitration on ties;
// without it the LSU wins every tie.

module ysyx_23060240_axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rvalid,
  output logic              s_rready,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t            state;
  logic              owner_q;
  logic [DATA_W-1:0] rbuf;
  logic              grant;
  logic              owner_arvalid;
  logic              owner_rready;
  logic              in_addr;
  logic              in_resp;

`ifdef ARB_RR_EN
  // Master granted by the most recent IDLE decision; starts at 1 so the
  // IFU wins the first tie after reset.
  logic last;
`endif

  // A lone requester always wins; only the tie rule differs between modes.
  always_comb begin
    grant = m1_arvalid;
`ifdef ARB_RR_EN
    if (m0_arvalid && m1_arvalid) begin
      grant = ~last;
    end
`endif
  end

  assign owner_arvalid = owner_q ? m1_arvalid : m0_arvalid;
  assign owner_rready  = owner_q ? m1_rready  : m0_rready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      owner_q <= 1'b0;
      rbuf    <= '0;
`ifdef ARB_RR_EN
      last    <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (m0_arvalid || m1_arvalid) begin
            owner_q <= grant;
`ifdef ARB_RR_EN
            last    <= grant;
`endif
            state   <= ADDR;
          end
        end
        // An owner that drops arvalid here simply keeps the arbiter in ADDR.
        ADDR: begin
          if (owner_arvalid && s_arready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (s_rvalid) begin
            rbuf  <= s_rdata;
            state <= RESP;
          end
        end
        RESP: begin
          if (owner_rready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_addr = (state == ADDR);
  assign in_resp = (state == RESP);

  // Address phase is a combinational pass-through from the owner.
  assign s_araddr   = in_addr ? (owner_q ? m1_araddr : m0_araddr) : '0;
  assign s_arvalid  = in_addr & owner_arvalid;
  assign m0_arready = in_addr & ~owner_q & s_arready;
  assign m1_arready = in_addr &  owner_q & s_arready;

  // Data phase is driven only from registered state and the response buffer.
  assign s_rready  = (state == WAIT);
  assign m0_rvalid = in_resp & ~owner_q;
  assign m1_rvalid = in_resp &  owner_q;
  assign m0_rdata  = m0_rvalid ? rbuf : '0;
  assign m1_rdata  = m1_rvalid ? rbuf : '0;

  assign busy  = (state != IDLE);
  assign owner = owner_q;

endmodule

// File: tb/tb_ysyx_23060240_axi_rd_arbiter.sv
// tb/tb_ysyx_23060240_axi_rd_arbiter.sv - self-checking bench for the read arbiter

module tb_ysyx_23060240_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_araddr, m1_araddr, s_araddr, s_rdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic        busy, owner;

  ysyx_23060240_axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  logic [103:0] all_outs;
  assign all_outs = {m0_arready, m0_rdata, m0_rvalid, m1_arready, m1_rdata, m1_rvalid,
                     s_araddr, s_arvalid, s_rready, busy, owner};

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave memory contents as a function of address.
  function automatic logic [31:0] sram_data(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h1234_5678);
  endfunction

  // Directed-phase bookkeeping.
  int          cyc;
  int          rx0_cyc, rx1_cyc;
  logic [31:0] rx0_data, rx1_data;
  logic [31:0] ar_log[$];
  bit          m1_noise;

  task automatic clear_log();
    cyc = 0; rx0_cyc = -1; rx1_cyc = -1; rx0_data = '0; rx1_data = '0;
    ar_log.delete(); m1_noise = 1'b0;
  endtask

  // Simple well-behaved masters and slave: masters drop arvalid after their
  // handshake, slave pulses rvalid for one cycle right after the AR handshake.
  task automatic serve(input int n);
    for (int i = 0; i < n; i++) begin
      logic        hs0, hs1, ar_seen;
      logic [31:0] ar_a;
      @(negedge clk);
      if (m0_rvalid && m0_rready && rx0_cyc < 0) begin rx0_cyc = cyc; rx0_data = m0_rdata; end
      if (m1_rvalid && m1_rready && rx1_cyc < 0) begin rx1_cyc = cyc; rx1_data = m1_rdata; end
      if (m1_arready || m1_rvalid || (m1_rdata != 32'h0)) m1_noise = 1'b1;
      hs0 = m0_arready && m0_arvalid;
      hs1 = m1_arready && m1_arvalid;
      ar_seen = s_arvalid && s_arready;
      ar_a = s_araddr;
      if (ar_seen) ar_log.push_back(ar_a);
      @(posedge clk); #1;
      cyc++;
      s_rvalid = 1'b0;
      if (ar_seen) begin s_rvalid = 1'b1; s_rdata = sram_data(ar_a); end
      if (hs0) m0_arvalid = 1'b0;
      if (hs1) m1_arvalid = 1'b0;
    end
  endtask

  // Transaction-level reference model for the random phase.
  bit          a_act, a_done, r_pend, mo;
`ifdef ARB_RR_EN
  bit          mlast;
`endif
  bit          req[2], wresp[2], rr[2];
  logic [31:0] addr[2], iss[2];
  bit          s_pend;
  int          s_cnt, ntx;
  logic [31:0] s_addr;

  initial begin
    bit in_a, do_grant, g, tie_winner, ar_hs, cap, r_hs;
    rst = 1'b0;
    m0_araddr = '0; m0_arvalid = 0; m0_rready = 0;
    m1_araddr = '0; m1_arvalid = 0; m1_rready = 0;
    s_arready = 0; s_rdata = '0; s_rvalid = 0;

    // Reset state.
    #12;
    chk("reset_outs", all_outs, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // IFU alone.
    clear_log();
    m0_araddr = 32'h8000_0000; m0_arvalid = 1; m0_rready = 1; m1_rready = 1; s_arready = 1;
    serve(6);
    chk("ifu_rvalid_cycle", rx0_cyc, 3);
    chk("ifu_rdata", rx0_data, 32'h0000_0413);
    chk("ifu_owner", owner, 0);
    chk("ifu_m1_quiet", m1_noise, 0);
    chk("ifu_ar_count", ar_log.size(), 1);

    // Simultaneous requests.
    clear_log();
    m0_araddr = 32'h8000_0004; m0_arvalid = 1;
    m1_araddr = 32'h8000_1000; m1_arvalid = 1;
    serve(14);
    chk("tie_ar_count", ar_log.size(), 2);
    if (ar_log.size() == 2) begin
`ifdef ARB_RR_EN
      chk("tie_first", ar_log[0], 32'h8000_0004);
      chk("tie_second", ar_log[1], 32'h8000_1000);
`else
      chk("tie_first", ar_log[0], 32'h8000_1000);
      chk("tie_second", ar_log[1], 32'h8000_0004);
`endif
    end
    chk("tie_m0_data", rx0_data, sram_data(32'h8000_0004));
    chk("tie_m1_data", rx1_data, sram_data(32'h8000_1000));
`ifdef ARB_RR_EN
    chk("tie_owner_kept", owner, 1);
`else
    chk("tie_owner_kept", owner, 0);
`endif

    // Reset while waiting for slave data.
    clear_log();
    m0_araddr = 32'h8000_0008; m0_arvalid = 1;
    serve(2);
    #2;
    chk("midrst_in_wait", s_rready, 1);
    rst = 1'b0;
    #1;
    chk("midrst_outs", all_outs, 0);
    s_rvalid = 0; m0_arvalid = 0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    clear_log();
    m1_araddr = 32'h8000_2000; m1_arvalid = 1;
    serve(6);
    chk("after_rst_cycle", rx1_cyc, 3);
    chk("after_rst_data", rx1_data, sram_data(32'h8000_2000));
    chk("after_rst_owner", owner, 1);

    // Randomised traffic against the reference model.
    rst = 1'b0;
    m0_arvalid = 0; m1_arvalid = 0; s_rvalid = 0; s_arready = 0;
    @(negedge clk); rst = 1'b1;
    a_act = 0; a_done = 0; r_pend = 0; mo = 0;
`ifdef ARB_RR_EN
    mlast = 1;
`endif
    s_pend = 0; s_cnt = 0; s_addr = '0; ntx = 0;
    for (int x = 0; x < 2; x++) begin req[x] = 0; wresp[x] = 0; addr[x] = '0; iss[x] = '0; end

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int x = 0; x < 2; x++) begin
        if (!req[x] && !wresp[x] && ($urandom % 3 == 0)) begin
          req[x] = 1; addr[x] = $urandom & 32'hFFFF_FFFC;
        end
        rr[x] = ($urandom % 3) != 0;
      end
      m0_arvalid = req[0]; m0_araddr = addr[0]; m0_rready = rr[0];
      m1_arvalid = req[1]; m1_araddr = addr[1]; m1_rready = rr[1];
      s_arready = ($urandom % 2) == 1;
      if (s_pend && s_cnt == 0) begin s_rvalid = 1; s_rdata = sram_data(s_addr); end
      else begin s_rvalid = 0; s_rdata = $urandom; end
      #1;
      in_a = a_act && !a_done;
      chk("busy", busy, a_act);
      chk("owner", owner, mo);
      chk("s_arvalid", s_arvalid, in_a ? req[mo] : 1'b0);
      chk("s_araddr", s_araddr, in_a ? addr[mo] : 32'h0);
      chk("m0_arready", m0_arready, in_a && !mo && s_arready);
      chk("m1_arready", m1_arready, in_a && mo && s_arready);
      chk("s_rready", s_rready, a_act && a_done && !r_pend);
      chk("m0_rvalid", m0_rvalid, r_pend && !mo);
      chk("m1_rvalid", m1_rvalid, r_pend && mo);
      chk("m0_rdata", m0_rdata, (r_pend && !mo) ? sram_data(iss[0]) : 32'h0);
      chk("m1_rdata", m1_rdata, (r_pend && mo) ? sram_data(iss[1]) : 32'h0);

`ifdef ARB_RR_EN
      tie_winner = !mlast;
`else
      tie_winner = 1'b1;
`endif
      g        = (req[0] && req[1]) ? tie_winner : req[1];
      do_grant = !a_act && (req[0] || req[1]);
      ar_hs    = in_a && req[mo] && s_arready;
      cap      = a_act && a_done && !r_pend && s_rvalid;
      r_hs     = r_pend && rr[mo];

      @(posedge clk);
      if (do_grant) begin
        a_act = 1; a_done = 0; r_pend = 0; mo = g;
`ifdef ARB_RR_EN
        mlast = g;
`endif
      end
      if (s_pend) begin
        if (s_rvalid) s_pend = 0;
        else s_cnt--;
      end
      if (ar_hs) begin
        a_done = 1; req[mo] = 0; wresp[mo] = 1; iss[mo] = addr[mo];
        s_pend = 1; s_addr = addr[mo]; s_cnt = $urandom % 3;
      end
      if (cap) r_pend = 1;
      if (r_hs) begin
        a_act = 0; r_pend = 0; wresp[mo] = 0; ntx++;
      end
    end
    chk("random_progress", ntx > 50, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
